// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared definitions for the boot-time program loader:
//                FSM state encodings, error codes and stream framing constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Bytes per packed instruction in the host stream
    localparam int INST_BYTES = 3;

    typedef logic [2:0] state_t;
    typedef logic [2:0] err_code_t;

    // Loader FSM states
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_LOAD  = 3'd1;
    localparam state_t S_WRITE = 3'd2;
    localparam state_t S_CHECK = 3'd3;
    localparam state_t S_DONE  = 3'd4;
    localparam state_t S_ERROR = 3'd5;

    // Abort reasons reported on err_code
    localparam err_code_t ERR_NONE       = 3'd0;
    localparam err_code_t ERR_ZERO_COUNT = 3'd1;
    localparam err_code_t ERR_RESERVED   = 3'd2;
    localparam err_code_t ERR_CHECKSUM   = 3'd3;
    localparam err_code_t ERR_TIMEOUT    = 3'd4;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_if
//  Description : Host byte stream, restart control, inst_mem write port and
//                status signals of the program loader.
//                master : host / system side (drives stream and restart)
//                slave  : loader side (drives ready, write port, status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 19,
    parameter int BYTE_W = 8
) ();
    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              restart;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [INST_W-1:0] im_wdata;
    logic              cpu_reset;
    logic              done;
    logic              err;
    logic [2:0]        err_code;
    logic [ADDR_W-1:0] loaded;

    modport master (
        output in_valid, in_data, restart,
        input  in_ready, im_we, im_addr, im_wdata, cpu_reset, done, err, err_code, loaded
    );

    modport slave (
        input  in_valid, in_data, restart,
        output in_ready, im_we, im_addr, im_wdata, cpu_reset, done, err, err_code, loaded
    );
endinterface : prog_loader_if
`default_nettype wire

// File: rtl/prog_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Shifts in stream bytes MSB-first and packs groups of
//                INST_BYTES bytes into one instruction word.
//  Ports       : clk, rst      - clock, async active-high reset
//                i_clear       - synchronous re-arm of the byte index
//                i_valid       - a payload byte is transferred this cycle
//                i_byte        - the payload byte
//                o_word_valid  - this transfer completes a word
//                o_rsv_err     - leading byte of a word has reserved bits set
//                o_word        - packed word (valid after o_word_valid edge)
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import loader_pkg::*;
#(
    parameter int BYTE_W = 8,
    parameter int INST_W = 19
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_clear,
    input  wire logic              i_valid,
    input  wire logic [BYTE_W-1:0] i_byte,
    output logic                   o_word_valid,
    output logic                   o_rsv_err,
    output logic [INST_W-1:0]      o_word
);

    // Only the low bits of the leading byte carry instruction data
    localparam int         RSV_LSB  = INST_W - (INST_BYTES - 1) * BYTE_W;
    localparam logic [1:0] LAST_IDX = 2'(INST_BYTES - 1);

    logic [1:0]        r_idx;
    logic [INST_W-1:0] r_shift;
    logic              w_first;

    assign w_first      = (r_idx == 2'd0);
    assign o_rsv_err    = i_valid && w_first && (i_byte[BYTE_W-1:RSV_LSB] != '0);
    assign o_word_valid = i_valid && (r_idx == LAST_IDX);
    assign o_word       = r_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= 2'd0;
            r_shift <= '0;
        end else if (i_clear) begin
            r_idx   <= 2'd0;
        end else if (i_valid) begin
            // Truncating shift: after three bytes the top bits hold b2[2:0]
            r_shift <= {r_shift[INST_W-BYTE_W-1:0], i_byte};
            r_idx   <= (r_idx == LAST_IDX) ? 2'd0 : r_idx + 2'd1;
        end
    end

endmodule : byte_packer
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Boot-time program loader. Receives [N][b2 b1 b0]xN[CK],
//                writes N 19-bit instructions into inst_mem and releases the
//                cpu reset once the XOR checksum of the image matches.
//  Ports       : clk    - clock
//                reset  - asynchronous active-high reset
//                bus    - prog_loader_if.slave (stream in, restart,
//                         inst_mem write port, cpu_reset and status)
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INST_W  = 19,
    parameter int BYTE_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  wire logic clk,
    input  wire logic reset,
    prog_loader_if.slave bus
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t            r_state;
    state_t            w_next;
    err_code_t         r_err_code;
    err_code_t         w_err_next;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_loaded;
    logic [BYTE_W-1:0] r_chk;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_cpu_reset;

    logic              w_in_ready;
    logic              w_xfer;
    logic              w_tmo_active;
    logic              w_tmo_hit;
    logic              w_word_valid;
    logic              w_rsv_err;
    logic [INST_W-1:0] w_word;

    assign w_in_ready   = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_CHECK);
    assign w_xfer       = bus.in_valid && w_in_ready;
    assign w_tmo_active = (r_state == S_LOAD) || (r_state == S_CHECK);
    // Fires on the idle cycle that would bring the counter up to TIMEOUT
    assign w_tmo_hit    = w_tmo_active && !w_xfer && (r_tmo == TMO_W'(TIMEOUT - 1));

    byte_packer #(
        .BYTE_W (BYTE_W),
        .INST_W (INST_W)
    ) u_packer (
        .clk          (clk),
        .rst          (reset),
        .i_clear      (r_state == S_IDLE),
        .i_valid      (w_xfer && (r_state == S_LOAD)),
        .i_byte       (bus.in_data),
        .o_word_valid (w_word_valid),
        .o_rsv_err    (w_rsv_err),
        .o_word       (w_word)
    );

    always_comb begin
        w_next     = r_state;
        w_err_next = r_err_code;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (bus.in_data == '0) begin
                        w_next     = S_ERROR;
                        w_err_next = ERR_ZERO_COUNT;
                    end else begin
                        w_next = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    if (w_rsv_err) begin
                        w_next     = S_ERROR;
                        w_err_next = ERR_RESERVED;
                    end else if (w_word_valid) begin
                        w_next = S_WRITE;
                    end
                end else if (w_tmo_hit) begin
                    w_next     = S_ERROR;
                    w_err_next = ERR_TIMEOUT;
                end
            end
            S_WRITE: begin
                w_next = (r_loaded + ADDR_W'(1) == r_count) ? S_CHECK : S_LOAD;
            end
            S_CHECK: begin
                if (w_xfer) begin
                    if (bus.in_data == r_chk) begin
                        w_next = S_DONE;
                    end else begin
                        w_next     = S_ERROR;
                        w_err_next = ERR_CHECKSUM;
                    end
                end else if (w_tmo_hit) begin
                    w_next     = S_ERROR;
                    w_err_next = ERR_TIMEOUT;
                end
            end
            S_DONE, S_ERROR: begin
                if (bus.restart) begin
                    w_next     = S_IDLE;
                    w_err_next = ERR_NONE;
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_err_next = ERR_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_err_code  <= ERR_NONE;
            r_count     <= '0;
            r_loaded    <= '0;
            r_chk       <= '0;
            r_tmo       <= '0;
            r_cpu_reset <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_err_code  <= w_err_next;
            // Registered so the cpu reset line cannot glitch on state decode
            r_cpu_reset <= (w_next != S_DONE);

            if (w_tmo_active && !w_xfer) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end else begin
                r_tmo <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_count <= ADDR_W'(bus.in_data);
                        r_chk   <= bus.in_data;
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_chk <= r_chk ^ bus.in_data;
                    end
                end
                S_WRITE: begin
                    r_loaded <= r_loaded + ADDR_W'(1);
                end
                S_DONE, S_ERROR: begin
                    if (bus.restart) begin
                        r_loaded <= '0;
                        r_chk    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.im_we     = (r_state == S_WRITE);
    assign bus.im_addr   = r_loaded;
    assign bus.im_wdata  = w_word;
    assign bus.cpu_reset = r_cpu_reset;
    assign bus.done      = (r_state == S_DONE);
    assign bus.err       = (r_state == S_ERROR);
    assign bus.err_code  = r_err_code;
    assign bus.loaded    = r_loaded;

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader. Expected inst_mem
//                writes are queued when a stream is driven and popped by a
//                write monitor; status is checked inline by each scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [18:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;

    prog_loader_if #(.ADDR_W(8), .INST_W(19), .BYTE_W(8)) bus ();

    prog_loader #(
        .ADDR_W  (8),
        .INST_W  (19),
        .BYTE_W  (8),
        .TIMEOUT (1024)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] stim_q[$];

    // Reset-value image of {in_ready, im_we, im_addr, im_wdata, cpu_reset, done, err, err_code, loaded}
    localparam logic [42:0] RST_IMG = {1'b1, 1'b0, 8'h00, 19'h0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};

    // Write monitor / scoreboard
    always @(negedge clk) begin
        if (!reset && bus.im_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", bus.im_addr, bus.im_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.im_addr !== mon_e.addr || bus.im_wdata !== mon_e.data) begin
                    n_err++;
                    $display("FAIL im_write: got addr=%h data=%h, required addr=%h data=%h",
                             bus.im_addr, bus.im_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    // Sends one byte; returns 1 time unit after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready=%b for byte %h, required 1", bus.in_ready, b);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives stim_q back to back; in_valid stays high across WRITE cycles
    task automatic send_stim();
        while (stim_q.size() > 0) send_byte(stim_q.pop_front());
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        @(posedge clk);
        #1;
        bus.restart = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.restart  = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.in_ready, bus.im_we, bus.im_addr, bus.im_wdata, bus.cpu_reset, bus.done,
             bus.err, bus.err_code, bus.loaded} !== RST_IMG) begin
            n_err++;
            $display("FAIL reset_values: got %h, required %h",
                     {bus.in_ready, bus.im_we, bus.im_addr, bus.im_wdata, bus.cpu_reset,
                      bus.done, bus.err, bus.err_code, bus.loaded}, RST_IMG);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_ok();
        exp_q.push_back('{addr: 8'd0, data: 19'h12345});
        exp_q.push_back('{addr: 8'd1, data: 19'h7FFFF});
        stim_q = '{8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF, 8'h62};
        send_stim();
        n_cmp++;
        if ({bus.done, bus.cpu_reset, bus.err, bus.in_ready} !== 4'b1000) begin
            n_err++;
            $display("FAIL load_ok_status: got done,cpu_reset,err,in_ready=%b, required 1000",
                     {bus.done, bus.cpu_reset, bus.err, bus.in_ready});
        end
        n_cmp++;
        if (bus.loaded !== 8'd2) begin
            n_err++;
            $display("FAIL load_ok_loaded: got %0d, required 2", bus.loaded);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL load_ok_writes: %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_reserved();
        stim_q = '{8'h01, 8'h08};
        send_stim();
        n_cmp++;
        if ({bus.err, bus.err_code, bus.cpu_reset, bus.in_ready} !== {1'b1, 3'd2, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reserved_status: got err,code,cpu_reset,in_ready=%b, required 1_010_1_0",
                     {bus.err, bus.err_code, bus.cpu_reset, bus.in_ready});
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.loaded !== 8'd0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reserved_loaded: got loaded=%0d done=%b, required 0 0", bus.loaded, bus.done);
        end
    endtask

    task automatic test_zero_count();
        stim_q = '{8'h00};
        send_stim();
        n_cmp++;
        if ({bus.err, bus.err_code, bus.in_ready, bus.cpu_reset} !== {1'b1, 3'd1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL zero_count: got err,code,in_ready,cpu_reset=%b, required 1_001_0_1",
                     {bus.err, bus.err_code, bus.in_ready, bus.cpu_reset});
        end
    endtask

    task automatic test_bad_checksum();
        exp_q.push_back('{addr: 8'd0, data: 19'h12345});
        exp_q.push_back('{addr: 8'd1, data: 19'h7FFFF});
        stim_q = '{8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF, 8'h63};
        send_stim();
        n_cmp++;
        if ({bus.err, bus.err_code, bus.done, bus.cpu_reset} !== {1'b1, 3'd3, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL bad_checksum: got err,code,done,cpu_reset=%b, required 1_011_0_1",
                     {bus.err, bus.err_code, bus.done, bus.cpu_reset});
        end
        n_cmp++;
        if (bus.loaded !== 8'd2 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bad_checksum_writes: got loaded=%0d pending=%0d, required 2 0",
                     bus.loaded, exp_q.size());
        end
    endtask

    task automatic test_timeout_restart();
        int t = 0;
        stim_q = '{8'h01};
        send_stim();
        while (bus.err !== 1'b1 && t < 1100) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_cmp++;
        if (t != 1024 || bus.err_code !== 3'd4) begin
            n_err++;
            $display("FAIL timeout: got err after %0d cycles code=%0d, required 1024 cycles code=4",
                     t, bus.err_code);
        end
        pulse_restart();
        n_cmp++;
        if ({bus.in_ready, bus.cpu_reset, bus.done, bus.err, bus.err_code, bus.loaded} !==
            {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0}) begin
            n_err++;
            $display("FAIL restart_clear: got in_ready,cpu_reset,done,err,code,loaded=%b, required 1_1_0_0_000_00000000",
                     {bus.in_ready, bus.cpu_reset, bus.done, bus.err, bus.err_code, bus.loaded});
        end
        test_load_ok();
    endtask

    task automatic test_reset_midload();
        stim_q = '{8'h02, 8'h01, 8'h23, 8'h45};
        send_stim();
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.im_we, bus.im_addr, bus.im_wdata, bus.cpu_reset, bus.done,
             bus.err, bus.err_code, bus.loaded} !== RST_IMG) begin
            n_err++;
            $display("FAIL midload_reset: got %h, required %h",
                     {bus.in_ready, bus.im_we, bus.im_addr, bus.im_wdata, bus.cpu_reset,
                      bus.done, bus.err, bus.err_code, bus.loaded}, RST_IMG);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_load_ok();
    endtask

    initial begin
        test_reset();
        test_load_ok();
        pulse_restart();
        test_reserved();
        pulse_restart();
        test_zero_count();
        pulse_restart();
        test_bad_checksum();
        pulse_restart();
        test_timeout_restart();
        pulse_restart();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_prog_loader
`default_nettype wire
